// File: rtl/wall_follower_robot.sv
// Left-hand wall-following controller for the pipe-cleaning robot.
// One registered action per cycle (front/turn/remove); halts on exit cell or watchdog.
module wall_follower_robot #(
    parameter int REMOVE_CYCLES  = 3,
    parameter int RIGHT_TURNS    = 3,
    parameter int MAX_IDLE_TURNS = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic head,
    input  logic left,
    input  logic under,
    input  logic barrier,
    output logic front,
    output logic turn,
    output logic remove,
    output logic done,
    output logic stuck
);

    localparam int RTW = $clog2(RIGHT_TURNS + 1);
    localparam int RMW = $clog2(REMOVE_CYCLES + 1);
    localparam int IW  = $clog2(MAX_IDLE_TURNS + 1);

    localparam logic [RTW-1:0] ROT_LAST = RTW'(RIGHT_TURNS - 1);
    localparam logic [RMW-1:0] RM_LAST  = RMW'(REMOVE_CYCLES);
    localparam logic [IW-1:0]  IDLE_MAX = IW'(MAX_IDLE_TURNS);

    typedef enum logic [2:0] {SEARCH, FOLLOW, ROTATE, REMOVE, STOP} state_t;

    state_t          state, state_n, ret_state, ret_n;
    logic            after_left, after_left_n;
    logic [RTW-1:0]  rot_cnt, rot_n;
    logic [RMW-1:0]  rm_cnt, rm_n;
    logic [IW-1:0]   idle_cnt, idle_n;
    logic            front_n, turn_n, remove_n, done_n, stuck_n;
    logic            watchdog;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= SEARCH;
            ret_state  <= SEARCH;
            after_left <= 1'b0;
            rot_cnt    <= '0;
            rm_cnt     <= '0;
            idle_cnt   <= '0;
            front      <= 1'b0;
            turn       <= 1'b0;
            remove     <= 1'b0;
            done       <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            state      <= state_n;
            ret_state  <= ret_n;
            after_left <= after_left_n;
            rot_cnt    <= rot_n;
            rm_cnt     <= rm_n;
            idle_cnt   <= idle_n;
            front      <= front_n;
            turn       <= turn_n;
            remove     <= remove_n;
            done       <= done_n;
            stuck      <= stuck_n;
        end
    end

    always_comb begin
        state_n      = state;
        ret_n        = ret_state;
        after_left_n = after_left;
        rot_n        = rot_cnt;
        rm_n         = rm_cnt;
        front_n      = 1'b0;
        turn_n       = 1'b0;
        remove_n     = 1'b0;
        done_n       = done;
        stuck_n      = stuck;
        watchdog     = (idle_cnt == IDLE_MAX);

        case (state)
            SEARCH, FOLLOW: begin
                if (under) begin
                    state_n = STOP;
                    done_n  = 1'b1;
                end else if (watchdog) begin
                    state_n = STOP;
                    done_n  = 1'b1;
                    stuck_n = 1'b1;
                end else if (barrier) begin
                    state_n  = REMOVE;
                    ret_n    = state;
                    remove_n = 1'b1;
                    rm_n     = RMW'(1);
                end else if (state == FOLLOW || left) begin
                    state_n = FOLLOW;
                    if (!left && !after_left) begin
                        turn_n       = 1'b1;
                        after_left_n = 1'b1;
                    end else if (!head) begin
                        front_n      = 1'b1;
                        after_left_n = 1'b0;
                    end else begin
                        // first right-turn cycle issued here; ROTATE supplies the rest
                        turn_n       = 1'b1;
                        after_left_n = 1'b0;
                        if (RIGHT_TURNS > 1) begin
                            state_n = ROTATE;
                            rot_n   = RTW'(1);
                        end
                    end
                end else if (!head) begin
                    front_n = 1'b1;
                end else begin
                    turn_n = 1'b1;
                    if (RIGHT_TURNS > 1) begin
                        state_n = ROTATE;
                        rot_n   = RTW'(1);
                    end else begin
                        state_n = FOLLOW;
                    end
                end
            end
            ROTATE: begin
                if (watchdog) begin
                    state_n = STOP;
                    done_n  = 1'b1;
                    stuck_n = 1'b1;
                    rot_n   = '0;
                end else begin
                    turn_n = 1'b1;
                    if (rot_cnt == ROT_LAST) begin
                        state_n = FOLLOW;
                        rot_n   = '0;
                    end else begin
                        rot_n = rot_cnt + RTW'(1);
                    end
                end
            end
            REMOVE: begin
                if (watchdog) begin
                    state_n = STOP;
                    done_n  = 1'b1;
                    stuck_n = 1'b1;
                    rm_n    = '0;
                end else if (rm_cnt == RM_LAST) begin
                    // one quiet cycle so the world can update the map
                    state_n = ret_state;
                    rm_n    = '0;
                end else begin
                    remove_n = 1'b1;
                    rm_n     = rm_cnt + RMW'(1);
                end
            end
            STOP: begin
            end
            default: state_n = SEARCH;
        endcase

        if (turn_n)
            idle_n = watchdog ? idle_cnt : idle_cnt + IW'(1);
        else if (front_n || remove_n)
            idle_n = '0;
        else
            idle_n = idle_cnt;
    end

endmodule

// File: tb/tb_wall_follower_robot.sv
// Self-checking bench: directed scenarios plus randomized sensors against a plan-queue reference model.
module tb_wall_follower_robot;

    localparam int RC = 3;
    localparam int RT = 3;
    localparam int MI = 8;

    logic clock = 1'b0;
    logic reset, head, left, under, barrier;
    logic front, turn, remove, done, stuck;

    int total = 0;
    int bad   = 0;

    wall_follower_robot #(
        .REMOVE_CYCLES (RC),
        .RIGHT_TURNS   (RT),
        .MAX_IDLE_TURNS(MI)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .head   (head),
        .left   (left),
        .under  (under),
        .barrier(barrier),
        .front  (front),
        .turn   (turn),
        .remove (remove),
        .done   (done),
        .stuck  (stuck)
    );

    always #5 clock = ~clock;

    // Model: committed multi-cycle actions sit in a queue (0 idle, 1 front, 2 turn, 3 remove).
    int plan[$];
    bit m_wall, m_after, m_halt, m_stuck;
    int m_turns;
    int m_act;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        plan.delete();
        m_wall  = 0;
        m_after = 0;
        m_halt  = 0;
        m_stuck = 0;
        m_turns = 0;
        m_act   = 0;
    endfunction

    function automatic void model_step(input bit h, input bit l, input bit u, input bit b);
        m_act = 0;
        if (m_halt) begin
        end else if (plan.size() == 0 && u) begin
            m_halt = 1;
        end else if (m_turns >= MI) begin
            m_halt  = 1;
            m_stuck = 1;
        end else if (plan.size() != 0) begin
            m_act = plan.pop_front();
        end else if (b) begin
            m_act = 3;
            repeat (RC - 1) plan.push_back(3);
            plan.push_back(0);
        end else begin
            if (l) m_wall = 1;
            if (m_wall && !l && !m_after) begin
                m_act   = 2;
                m_after = 1;
            end else if (!h) begin
                m_act   = 1;
                m_after = 0;
            end else begin
                m_act = 2;
                repeat (RT - 1) plan.push_back(2);
                m_wall  = 1;
                m_after = 0;
            end
        end
        if (m_act == 2) m_turns++;
        else if (m_act == 1 || m_act == 3) m_turns = 0;
    endfunction

    function automatic logic [4:0] model_out();
        return {m_act == 1, m_act == 2, m_act == 3, m_halt, m_stuck};
    endfunction

    task automatic cycle(input bit h, input bit l, input bit u, input bit b, input string tag);
        head    = h;
        left    = l;
        under   = u;
        barrier = b;
        model_step(h, l, u, b);
        @(posedge clock);
        #1;
        check_eq(tag, {front, turn, remove, done, stuck}, model_out());
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check_eq("reset_async", {front, turn, remove, done, stuck}, 5'b0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int nturn;
        int nrem;
        int halt_len;
        bit h, l, u, b;
        reset = 1'b0; head = 1'b0; left = 1'b0; under = 1'b0; barrier = 1'b0;
        #2;
        apply_reset();

        repeat (4) cycle(0, 0, 0, 0, "t1_search_front");
        check_eq("t1_front", front, 1'b1);
        check_eq("t1_done", done, 1'b0);

        nturn = 0;
        cycle(1, 0, 0, 0, "t2_rot0");
        nturn += int'(turn);
        repeat (2) begin
            cycle(1, 0, 0, 0, "t2_rot");
            nturn += int'(turn);
        end
        check_eq("t2_turn_cycles", nturn, 3);

        cycle(0, 0, 0, 0, "t3_left_turn");
        check_eq("t3_turn", turn, 1'b1);
        cycle(0, 0, 0, 0, "t3_then_front");
        check_eq("t3_no_second_left", {front, turn}, 2'b10);

        nrem = 0;
        cycle(0, 1, 0, 1, "t4_rm0");
        nrem += int'(remove);
        repeat (2) begin
            cycle(0, 1, 0, 0, "t4_rm");
            nrem += int'(remove);
        end
        check_eq("t4_remove_cycles", nrem, 3);
        cycle(0, 1, 0, 0, "t4_settle");
        check_eq("t4_settle_idle", {front, turn, remove}, 3'b000);
        cycle(0, 1, 0, 0, "t4_front");
        check_eq("t4_front_after", front, 1'b1);

        cycle(0, 1, 1, 0, "t5_exit");
        check_eq("t5_done", {front, turn, remove, done, stuck}, 5'b00010);
        repeat (10) cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "t5_hold");
        check_eq("t5_still_done", {done, stuck}, 2'b10);

        apply_reset();
        repeat (12) cycle(1, 1, 0, 0, "t6_spin");
        check_eq("t6_stuck", {done, stuck}, 2'b11);

        apply_reset();
        cycle(0, 0, 0, 1, "t6_rm_a");
        cycle(0, 0, 0, 0, "t6_rm_b");
        check_eq("t6_mid_remove", remove, 1'b1);
        apply_reset();
        check_eq("t6_after_reset", {front, turn, remove, done, stuck}, 5'b0);

        halt_len = 0;
        repeat (3000) begin
            if ($urandom_range(0, 149) == 0 || halt_len > 4) begin
                apply_reset();
                halt_len = 0;
            end else begin
                h = ($urandom_range(0, 1) == 1);
                l = ($urandom_range(0, 1) == 1);
                b = ($urandom_range(0, 7) == 0);
                u = ($urandom_range(0, 59) == 0);
                cycle(h, l, u, b, "rand");
                if (m_halt) halt_len++;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
